panda_risc_v_ifu_ctrl: RTL and testbench
========================================

Name: panda_risc_v_ifu_ctrl

Overview:
Instruction-fetch controller for the panda RISC-V front end.
- Owns the PC register.
- Sequences the instruction-memory request/response handshake, one outstanding access.
- Pre-decodes each fetched word and drives the combinational next-PC generator.
- Handles reset-load, flush redirect, backpressure from decode, and fetch errors.
- Delivers {inst, pc, to_jump, err} to decode through a one-entry output buffer.

Parameters:
RST_PC, 32'h0000_0000, PC value loaded on the first clock after reset release

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_req  in  1  redirect request, single-cycle pulse
flush_addr  in  32  redirect target, halfword aligned
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address (= pc)
imem_resp_valid  in  1  fetch data valid; always accepted
imem_resp_data  in  32  instruction word at requested address
imem_resp_err  in  1  access fault
rs1_id  out  5  regfile read index for JALR (resp_data[19:15])
rs1_v  in  32  regfile read data, combinational from rs1_id
pg_now_pc  out  32  to next-PC generator: current pc
pg_rst_req  out  1  to next-PC generator: load RST_PC
pg_flush_req  out  1  to next-PC generator: redirect
pg_flush_addr  out  32  to next-PC generator: flush_addr passthrough
pg_inst_len_type  out  1  0 = 16-bit, 1 = 32-bit
pg_is_b_inst  out  1  pre-decode flag
pg_is_jal_inst  out  1  pre-decode flag
pg_is_jalr_inst  out  1  pre-decode flag
pg_jump_ofs_imm  out  21  sign-extended branch/jump offset
pg_rs1_v  out  32  rs1_v passthrough
pg_to_jump  in  1  prediction from next-PC generator
pg_new_pc  in  32  next PC from next-PC generator
if_valid  out  1  instruction to decode valid
if_ready  in  1  decode accepts
if_inst  out  32  instruction
if_pc  out  32  address of if_inst
if_to_jump  out  1  predicted-taken flag
if_err  out  1  fetch fault flag

Behaviour:
- Reset values: state = S_RST, pc = RST_PC, discard = 0, if_valid = 0, if_inst/if_pc = 0, if_to_jump/if_err = 0, imem_req_valid = 0.
- States:
  - S_RST: pg_rst_req = 1; pc <= pg_new_pc; -> S_REQ after exactly 1 cycle.
  - S_REQ: imem_req_valid = 1 with addr = pc, held stable until ready. On handshake -> S_WAIT.
  - S_WAIT: on imem_resp_valid:
    - load the output buffer {resp_data, pc, pg_to_jump, resp_err};
    - if no err: pc <= pg_new_pc, -> S_HOLD;
    - if err: pc unchanged, -> S_HALT.
  - S_HOLD: if_valid = 1. On if_ready -> S_REQ; the request is issued the next cycle.
  - S_HALT: if_valid = 1 until accepted, then 0. No further fetch until flush.
- Pre-decode is combinational on imem_resp_data; outputs are don't-care outside S_WAIT.
  - inst_len_type = (data[1:0] == 2'b11).
  - 16-bit words: all jump flags = 0.
  - B (opcode 1100011): imm = {data[31], data[7], data[30:25], data[11:8], 0}, sign-extended to 21 bits.
  - JAL (1101111): imm = {data[31], data[19:12], data[20], data[30:21], 0}.
  - JALR (1100111): imm = sign-extended data[31:20].
- Flush (any state except S_RST, where it is ignored):
  - pg_flush_req = 1; pc <= pg_new_pc (= flush_addr); if_valid <= 0; -> S_REQ.
  - If an access is outstanding (state S_WAIT without resp this cycle, or S_REQ with handshake this cycle): set discard = 1 and go to S_WAIT instead.
  - A flush in the same cycle as imem_resp_valid: the response is dropped; flush wins.
- discard = 1: the next response is dropped (no buffer load, no pc update); discard <= 0; -> S_REQ.
- Backpressure: the output buffer contents stay stable while if_valid & !if_ready; no fetch is issued while the buffer is occupied.
- Throughput: at most one instruction per 3 cycles.
- Mid-operation rst: returns to S_RST the next edge and drops any outstanding state. The memory shares rst, so no stale response arrives.
- PC arithmetic: 32-bit, wraps modulo 2^32. 0xFFFF_FFFC + 4 = 0x0000_0000.

Decomposition:
- Shared package panda_risc_v_ifu_pkg:
  - state encodings S_RST/S_REQ/S_WAIT/S_HOLD/S_HALT;
  - opcode constants OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111.
- One sub-module: panda_risc_v_ifu_predecode, the combinational length/type/immediate extraction.

Test Plan:
- Reset release: RST_PC = 0x100 -> pg_rst_req for exactly 1 cycle, then imem_req_addr = 0x100.
- Sequential fetch: resp 0x00000013 at 0x100 -> if_pc = 0x100, next addr = 0x104. Resp 0x0001 (16-bit) at 0x104 -> next addr = 0x106.
- Branches:
  - beq, offset -8, at 0x110 -> if_to_jump = 1, next addr = 0x108;
  - beq, offset +8 -> if_to_jump = 0, next addr = 0x114.
- JALR with rs1_v = 0x2000, imm 0x10 -> rs1_id = data[19:15], next addr = 0x2010.
- Flush during S_WAIT to 0x400, response arrives 3 cycles later -> no if_valid, next request addr = 0x400.
- if_ready held low 5 cycles -> no imem_req_valid, if_inst/if_pc stable. resp_err = 1 -> if_err = 1, fetching stops until flush.

Source files
------------

// File: rtl/panda_risc_v_ifu_pkg.sv
// Shared definitions for the panda RISC-V instruction-fetch unit:
// controller state encoding and the opcodes the pre-decoder recognises.
package panda_risc_v_ifu_pkg;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } ifu_state_e;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/panda_risc_v_ifu_predecode.sv
// Combinational pre-decode of a fetched word: instruction length, the
// control-transfer type and its sign-extended 21-bit offset.
module panda_risc_v_ifu_predecode
    import panda_risc_v_ifu_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic        len32_o,
    output logic        is_b_o,
    output logic        is_jal_o,
    output logic        is_jalr_o,
    output logic [20:0] imm_o
);

    logic len32;

    assign len32   = (inst_i[1:0] == 2'b11);
    assign len32_o = len32;

    // Classify the word; compressed encodings never raise a jump flag.
    always_comb begin
        is_b_o    = 1'b0;
        is_jal_o  = 1'b0;
        is_jalr_o = 1'b0;
        imm_o     = '0;
        if (len32) begin
            case (inst_i[6:0])
                OP_BRANCH: begin
                    is_b_o = 1'b1;
                    imm_o  = {{8{inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
                end
                OP_JAL: begin
                    is_jal_o = 1'b1;
                    imm_o    = {inst_i[31], inst_i[19:12], inst_i[20],
                                inst_i[30:21], 1'b0};
                end
                OP_JALR: begin
                    is_jalr_o = 1'b1;
                    imm_o     = {{9{inst_i[31]}}, inst_i[31:20]};
                end
                default: begin
                    imm_o = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/panda_risc_v_ifu_ctrl.sv
// Instruction-fetch controller: owns the PC, runs a single-outstanding
// instruction-memory handshake and hands {inst, pc, to_jump, err} to decode
// through a one-entry buffer.
// Handshakes: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; valid and address stay stable until then.
// imem_resp_valid has no ready and is always consumed. The decode side
// transfers on if_valid & if_ready and the buffer is frozen until it does.
module panda_risc_v_ifu_ctrl
    import panda_risc_v_ifu_pkg::*;
#(
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_req,
    input  logic [31:0] flush_addr,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic [4:0]  rs1_id,
    input  logic [31:0] rs1_v,
    output logic [31:0] pg_now_pc,
    output logic        pg_rst_req,
    output logic        pg_flush_req,
    output logic [31:0] pg_flush_addr,
    output logic        pg_inst_len_type,
    output logic        pg_is_b_inst,
    output logic        pg_is_jal_inst,
    output logic        pg_is_jalr_inst,
    output logic [20:0] pg_jump_ofs_imm,
    output logic [31:0] pg_rs1_v,
    input  logic        pg_to_jump,
    input  logic [31:0] pg_new_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_to_jump,
    output logic        if_err,
    output logic [2:0]  dbg_state_o
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_to_jump_q, if_to_jump_d;
    logic        if_err_q, if_err_d;

    logic        req_hs;
    logic        flush_act;
    logic        outstanding;

    panda_risc_v_ifu_predecode u_predecode (
        .inst_i    (imem_resp_data),
        .len32_o   (pg_inst_len_type),
        .is_b_o    (pg_is_b_inst),
        .is_jal_o  (pg_is_jal_inst),
        .is_jalr_o (pg_is_jalr_inst),
        .imm_o     (pg_jump_ofs_imm)
    );

    assign req_hs    = (state_q == S_REQ) && imem_req_ready;
    // A redirect arriving before the first PC load has nothing to redirect.
    assign flush_act = flush_req && (state_q != S_RST);
    // A response is still owed by memory after this edge.
    assign outstanding = ((state_q == S_WAIT) && !imem_resp_valid) || req_hs;

    // Next-state, PC and output-buffer update; a flush overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        if_valid_d   = if_valid_q;
        if_inst_d    = if_inst_q;
        if_pc_d      = if_pc_q;
        if_to_jump_d = if_to_jump_q;
        if_err_d     = if_err_q;
        case (state_q)
            S_RST: begin
                pc_d    = pg_new_pc;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid && !flush_act) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        if_valid_d   = 1'b1;
                        if_inst_d    = imem_resp_data;
                        if_pc_d      = pc_q;
                        if_to_jump_d = pg_to_jump;
                        if_err_d     = imem_resp_err;
                        if (imem_resp_err) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pg_new_pc;
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_HALT: begin
                if (if_ready) if_valid_d = 1'b0;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
        if (flush_act) begin
            pc_d       = pg_new_pc;
            if_valid_d = 1'b0;
            discard_d  = outstanding;
            state_d    = outstanding ? S_WAIT : S_REQ;
        end
    end

    // State and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RST;
            pc_q         <= RST_PC;
            discard_q    <= 1'b0;
            if_valid_q   <= 1'b0;
            if_inst_q    <= '0;
            if_pc_q      <= '0;
            if_to_jump_q <= 1'b0;
            if_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            if_valid_q   <= if_valid_d;
            if_inst_q    <= if_inst_d;
            if_pc_q      <= if_pc_d;
            if_to_jump_q <= if_to_jump_d;
            if_err_q     <= if_err_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign rs1_id         = imem_resp_data[19:15];
    assign pg_now_pc      = pc_q;
    assign pg_rst_req     = (state_q == S_RST);
    assign pg_flush_req   = flush_act;
    assign pg_flush_addr  = flush_addr;
    assign pg_rs1_v       = rs1_v;
    assign if_valid       = if_valid_q;
    assign if_inst        = if_inst_q;
    assign if_pc          = if_pc_q;
    assign if_to_jump     = if_to_jump_q;
    assign if_err         = if_err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_panda_risc_v_ifu_ctrl.sv
// Bench for the fetch controller: memory, register file and next-PC
// generator models around the DUT, a transaction-level fetch model feeding
// an expected queue, and a directed program with literal expectations.
module tb_panda_risc_v_ifu_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic [31:0] flush_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic [4:0]  rs1_id;
    logic [31:0] rs1_v;
    logic [31:0] pg_now_pc;
    logic        pg_rst_req;
    logic        pg_flush_req;
    logic [31:0] pg_flush_addr;
    logic        pg_inst_len_type;
    logic        pg_is_b_inst;
    logic        pg_is_jal_inst;
    logic        pg_is_jalr_inst;
    logic [20:0] pg_jump_ofs_imm;
    logic [31:0] pg_rs1_v;
    logic        pg_to_jump;
    logic [31:0] pg_new_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_to_jump;
    logic        if_err;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] regs [32];
    int          mem_lat;
    logic [31:0] err_addr;
    logic [65:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    panda_risc_v_ifu_ctrl #(.RST_PC(RST_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_req        (flush_req),
        .flush_addr       (flush_addr),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .imem_resp_err    (imem_resp_err),
        .rs1_id           (rs1_id),
        .rs1_v            (rs1_v),
        .pg_now_pc        (pg_now_pc),
        .pg_rst_req       (pg_rst_req),
        .pg_flush_req     (pg_flush_req),
        .pg_flush_addr    (pg_flush_addr),
        .pg_inst_len_type (pg_inst_len_type),
        .pg_is_b_inst     (pg_is_b_inst),
        .pg_is_jal_inst   (pg_is_jal_inst),
        .pg_is_jalr_inst  (pg_is_jalr_inst),
        .pg_jump_ofs_imm  (pg_jump_ofs_imm),
        .pg_rs1_v         (pg_rs1_v),
        .pg_to_jump       (pg_to_jump),
        .pg_new_pc        (pg_new_pc),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_inst          (if_inst),
        .if_pc            (if_pc),
        .if_to_jump       (if_to_jump),
        .if_err           (if_err),
        .dbg_state_o      (dbg_state)
    );

    assign rs1_v = regs[rs1_id];

    // ---------------- environment: next-PC generator ----------------
    // Static prediction: jumps taken, backward branches taken.
    logic [31:0] gen_imm;
    always_comb begin
        gen_imm    = {{11{pg_jump_ofs_imm[20]}}, pg_jump_ofs_imm};
        pg_to_jump = 1'b0;
        pg_new_pc  = pg_now_pc + (pg_inst_len_type ? 32'd4 : 32'd2);
        if (pg_rst_req) begin
            pg_new_pc = RST_PC;
        end else if (pg_flush_req) begin
            pg_new_pc = pg_flush_addr;
        end else if (pg_is_jalr_inst) begin
            pg_to_jump = 1'b1;
            pg_new_pc  = pg_rs1_v + gen_imm;
        end else if (pg_is_jal_inst) begin
            pg_to_jump = 1'b1;
            pg_new_pc  = pg_now_pc + gen_imm;
        end else if (pg_is_b_inst && pg_jump_ofs_imm[20]) begin
            pg_to_jump = 1'b1;
            pg_new_pc  = pg_now_pc + gen_imm;
        end
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0000_0013;
    endfunction

    // Architectural next fetch address and prediction of the word d at a.
    function automatic logic [32:0] model_next(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] imm;
        if (d[1:0] != 2'b11) return {1'b0, a + 32'd2};
        case (d[6:0])
            7'b1101111: begin
                imm = {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
                return {1'b1, a + imm};
            end
            7'b1100111: begin
                imm = {{20{d[31]}}, d[31:20]};
                return {1'b1, regs[d[19:15]] + imm};
            end
            7'b1100011: begin
                imm = {{20{d[31]}}, d[7], d[30:25], d[11:8], 1'b0};
                if (d[31]) return {1'b1, a + imm};
                return {1'b0, a + 32'd4};
            end
            default: return {1'b0, a + 32'd4};
        endcase
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: condition violated at %0t", name, $time);
    endtask

    // ---------------- environment: instruction memory ----------------
    initial begin
        logic        hs_s, rst_s;
        logic [31:0] addr_s, baddr;
        int          lat_s, cnt;
        logic        busy;
        busy = 1'b0; cnt = 0; baddr = '0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
        forever begin
            @(negedge clk);
            rst_s  = rst;
            hs_s   = imem_req_valid && imem_req_ready && !rst;
            addr_s = imem_req_addr;
            lat_s  = mem_lat;
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            if (rst_s) begin
                busy = 1'b0;
            end else begin
                if (hs_s) begin
                    busy  = 1'b1;
                    baddr = addr_s;
                    cnt   = lat_s;
                end
                if (busy) begin
                    if (cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = mem_rd(baddr);
                        imem_resp_err   = (baddr == err_addr);
                        busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard / transaction model ----------------
    initial begin
        logic [31:0] exp_addr, out_addr, d;
        logic        outstanding, drop_next, halted, e;
        logic [32:0] nx;
        exp_addr = RST_PC; out_addr = '0;
        outstanding = 1'b0; drop_next = 1'b0; halted = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_addr = RST_PC; outstanding = 1'b0; drop_next = 1'b0; halted = 1'b0;
                exp_q.delete();
                continue;
            end
            if (if_valid) begin
                if (exp_q.size() == 0) begin
                    fail("if_unexpected");
                end else begin
                    chk("if_out", {if_inst, if_pc, if_to_jump, if_err}, exp_q[0]);
                    if (if_ready) void'(exp_q.pop_front());
                end
                if (imem_req_valid) fail("fetch_while_buffered");
            end
            if (imem_resp_valid) begin
                outstanding = 1'b0;
                if (!(drop_next || flush_req)) begin
                    d  = mem_rd(out_addr);
                    nx = model_next(out_addr, d);
                    e  = (out_addr == err_addr);
                    exp_q.push_back({d, out_addr, nx[32], e});
                    if (e) halted = 1'b1;
                    else exp_addr = nx[31:0];
                end
                drop_next = 1'b0;
            end
            if (imem_req_valid) begin
                if (halted) fail("fetch_after_err");
                chk("req_addr", {34'd0, imem_req_addr}, {34'd0, exp_addr});
                if (imem_req_ready) begin
                    outstanding = 1'b1;
                    out_addr    = exp_addr;
                end
            end
            if (flush_req) begin
                exp_addr = flush_addr;
                halted   = 1'b0;
                exp_q.delete();
                if (outstanding) drop_next = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_req(input logic [31:0] exp, input string name, output int seen_v);
        bit got;
        got = 1'b0;
        seen_v = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_valid) seen_v++;
            if (imem_req_valid && imem_req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail({name, "_timeout"});
        else chk(name, {34'd0, imem_req_addr}, {34'd0, exp});
    endtask

    task automatic wait_if(input logic [31:0] pc, input logic [31:0] inst, input logic tj,
                           input logic er, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail({name, "_timeout"});
        else chk(name, {if_inst, if_pc, if_to_jump, if_err}, {inst, pc, tj, er});
    endtask

    task automatic pulse_flush(input logic [31:0] a);
        @(posedge clk);
        #1;
        flush_req  = 1'b1;
        flush_addr = a;
        @(posedge clk);
        #1;
        flush_req  = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int seen;
        rst = 1'b1; flush_req = 1'b0; flush_addr = '0;
        imem_req_ready = 1'b1; if_ready = 1'b1; mem_lat = 0;
        err_addr = 32'hFFFF_FFF0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[5] = 32'h0000_2000;
        mem[32'h100] = 32'h0000_0013;   // nop
        mem[32'h104] = 32'h0000_0001;   // 16-bit word
        mem[32'h106] = 32'h00A0_006F;   // jal x0, +10 -> 0x110
        mem[32'h110] = 32'hFE00_0CE3;   // beq x0,x0,-8 -> 0x108
        mem[32'h108] = 32'h0000_0013;   // nop
        mem[32'h10C] = 32'h0102_8067;   // jalr x0, 0x10(x5)
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_valid", {65'd0, if_valid}, 66'd0);
        chk("rst_req_valid", {65'd0, imem_req_valid}, 66'd0);
        chk("rst_if_inst_pc", {2'b0, if_inst, if_pc}, 66'd0);
        chk("rst_if_flags", {64'd0, if_to_jump, if_err}, 66'd0);
        chk("rst_pg_rst_req", {65'd0, pg_rst_req}, 66'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_pg_rst_req", {65'd0, pg_rst_req}, 66'd1);
        chk("rel_no_req", {65'd0, imem_req_valid}, 66'd0);
        wait_req(32'h100, "rst_pc", seen);
        chk("rst_req_one_cycle", {65'd0, pg_rst_req}, 66'd0);
        wait_if(32'h100, 32'h0000_0013, 1'b0, 1'b0, "nop_if");
        wait_req(32'h104, "seq_4", seen);
        wait_req(32'h106, "seq_c16", seen);
        wait_req(32'h110, "jal", seen);
        wait_if(32'h110, 32'hFE00_0CE3, 1'b1, 1'b0, "beq_back_if");
        wait_req(32'h108, "beq_back", seen);
        wait_req(32'h10C, "after_nop", seen);
        @(negedge clk);
        chk("jalr_rs1_id", {61'd0, rs1_id}, 66'd5);
        chk("jalr_imm", {45'd0, pg_jump_ofs_imm}, 66'h10);
        wait_if(32'h10C, 32'h0102_8067, 1'b1, 1'b0, "jalr_if");
        wait_req(32'h2010, "jalr", seen);
        @(posedge clk);
        #1;
        mem_lat = 3;
        wait_req(32'h2014, "nop_2010", seen);
        pulse_flush(32'h400);
        mem_lat = 0;
        wait_req(32'h400, "flush_wait", seen);
        chk("flush_wait_no_if", 66'(seen), 66'd0);
        @(posedge clk);
        #1;
        if_ready = 1'b0;
        wait_if(32'h400, 32'h0000_0013, 1'b0, 1'b0, "bp_if");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stable", {imem_req_valid, if_valid, if_pc, if_inst},
                {1'b0, 1'b1, 32'h400, 32'h0000_0013});
        end
        mem[32'h110] = 32'h0000_0463;   // beq x0,x0,+8
        err_addr = 32'h114;
        pulse_flush(32'h110);
        if_ready = 1'b1;
        wait_req(32'h110, "flush_hold", seen);
        chk("flush_hold_no_if", 66'(seen), 66'd0);
        wait_if(32'h110, 32'h0000_0463, 1'b0, 1'b0, "beq_fwd_if");
        wait_req(32'h114, "beq_fwd", seen);
        wait_if(32'h114, 32'h0000_0013, 1'b0, 1'b1, "err_if");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("halt_idle", {64'd0, imem_req_valid, if_valid}, 66'd0);
        end
        pulse_flush(32'hFFFF_FFFC);
        wait_req(32'hFFFF_FFFC, "flush_halt", seen);
        wait_req(32'h0000_0000, "wrap", seen);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_if", {if_valid, if_to_jump, if_err, if_pc, 31'd0, imem_req_valid}, 66'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_pg_rst_req", {65'd0, pg_rst_req}, 66'd1);
        wait_req(32'h100, "mid_rst_pc", seen);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
